// File: rtl/axi_addr_router.sv
// AXI address-channel router: decodes an upstream address into one of NUM_SLAVES
// equal regions (or a decode-error sink) through a one-entry registered stage.
module axi_addr_router #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000),
  parameter int unsigned REGION_BITS = 9,
  parameter int unsigned MAX_OUTST = 4,
  localparam int unsigned SEL_W = $clog2(NUM_SLAVES + 1),
  localparam int unsigned CNT_W = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_W-1:0]     s_addr,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [NUM_SLAVES-1:0] m_valid,
  input  logic [NUM_SLAVES-1:0] m_ready,
  output logic                  err_valid,
  input  logic                  err_ready,
  input  logic                  resp_done,
  output logic [SEL_W-1:0]      resp_sel,
  output logic [CNT_W-1:0]      outst_cnt
);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << REGION_BITS) - 64'd1);

  logic [ADDR_W-1:0]     off_c;
  logic [ADDR_W-1:0]     idx_c;
  logic [ADDR_W-1:0]     fwd_c;
  logic                  err_c;
  logic [SEL_W-1:0]      dsel_c;
  logic [NUM_SLAVES-1:0] dvalid_c;
  logic                  full_c;
  logic                  fire_c;
  logic                  done_c;
  logic                  allow_c;
  logic                  s_fire_c;

  // Region decode; the below-base check keeps wrapped subtraction out of a region.
  always_comb begin
    off_c    = s_addr - BASE_ADDR;
    idx_c    = off_c >> REGION_BITS;
    err_c    = (s_addr < BASE_ADDR) || (idx_c >= ADDR_W'(NUM_SLAVES));
    dsel_c   = err_c ? SEL_W'(NUM_SLAVES) : SEL_W'(idx_c);
    fwd_c    = err_c ? s_addr : (off_c & LOW_MASK);
    dvalid_c = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      dvalid_c[i] = !err_c && (dsel_c == SEL_W'(i));
    end
  end

  // A completion arriving this cycle frees a slot for a same-stream request.
  always_comb begin
    full_c   = (|m_valid) || err_valid;
    fire_c   = (|(m_valid & m_ready)) || (err_valid && err_ready);
    done_c   = resp_done && (outst_cnt != '0);
    allow_c  = (outst_cnt == '0) ||
               ((dsel_c == resp_sel) && ((outst_cnt < CNT_W'(MAX_OUTST)) || done_c));
    s_ready  = !ARESET && (!full_c || fire_c) && allow_c;
    s_fire_c = s_valid && s_ready;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      m_valid   <= '0;
      err_valid <= 1'b0;
      m_addr    <= '0;
      resp_sel  <= '0;
      outst_cnt <= '0;
    end else begin
      if (s_fire_c) begin
        m_valid   <= dvalid_c;
        err_valid <= err_c;
        m_addr    <= fwd_c;
        resp_sel  <= dsel_c;
      end else if (fire_c) begin
        m_valid   <= '0;
        err_valid <= 1'b0;
      end
      if (s_fire_c && !done_c) begin
        outst_cnt <= outst_cnt + CNT_W'(1);
      end else if (!s_fire_c && done_c) begin
        outst_cnt <= outst_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_addr_router.sv
// Bench for axi_addr_router: directed vector table, corner-case sequences and a
// randomized run, all checked against a transaction-level model of the router.
module tb_axi_addr_router;

  localparam int          N      = 4;
  localparam int          MAXO   = 4;
  localparam longint      REGION = 512;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] s_addr;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_addr;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic        err_valid;
  logic        err_ready;
  logic        resp_done;
  logic [2:0]  resp_sel;
  logic [3:0]  outst_cnt;

  axi_addr_router dut (
    .ACLK(ACLK), .ARESET(ARESET), .s_addr(s_addr), .s_valid(s_valid),
    .s_ready(s_ready), .m_addr(m_addr), .m_valid(m_valid), .m_ready(m_ready),
    .err_valid(err_valid), .err_ready(err_ready), .resp_done(resp_done),
    .resp_sel(resp_sel), .outst_cnt(outst_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  // Model: held transaction plus a FIFO of targets still awaiting completion.
  bit          mdl_full = 1'b0;
  int          mdl_tgt  = 0;
  logic [31:0] mdl_addr = 32'h0;
  int          mdl_sel  = 0;
  int          outst_q[$];

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic longint offset_of(input logic [31:0] a);
    return longint'({32'h0, a}) - longint'({32'h0, BASE});
  endfunction

  function automatic int target_of(input logic [31:0] a);
    longint off = offset_of(a);
    if (off < 0 || off / REGION >= N) return N;
    return int'(off / REGION);
  endfunction

  function automatic logic [31:0] fwd_of(input logic [31:0] a);
    if (target_of(a) == N) return a;
    return 32'(offset_of(a) % REGION);
  endfunction

  function automatic bit drains(input logic [3:0] mr, input bit er);
    if (!mdl_full) return 1'b1;
    return (mdl_tgt < N) ? bit'(mr[mdl_tgt]) : er;
  endfunction

  function automatic bit exp_ready(input bit rst, input logic [31:0] a,
                                   input logic [3:0] mr, input bit er, input bit d);
    int cnt = outst_q.size();
    int t   = target_of(a);
    bit room;
    if (rst) return 1'b0;
    room = (cnt == 0) || (t == mdl_sel && (cnt < MAXO || (d && cnt > 0)));
    return drains(mr, er) && room;
  endfunction

  task automatic step(input bit rst, input bit v, input logic [31:0] a,
                      input logic [3:0] mr, input bit er, input bit d, output bit rdy);
    bit e;
    ARESET = rst; s_valid = v; s_addr = a; m_ready = mr; err_ready = er; resp_done = d;
    #1;
    e = exp_ready(rst, a, mr, er, d);
    chk("s_ready", 32'(s_ready), 32'(e));
    rdy = s_ready;
    if (rst) begin
      mdl_full = 1'b0; mdl_sel = 0; mdl_addr = 32'h0;
      outst_q.delete();
    end else begin
      if (d && outst_q.size() > 0) void'(outst_q.pop_front());
      if (mdl_full && drains(mr, er)) mdl_full = 1'b0;
      if (v && e) begin
        mdl_tgt  = target_of(a);
        mdl_full = 1'b1;
        mdl_addr = fwd_of(a);
        mdl_sel  = mdl_tgt;
        outst_q.push_back(mdl_tgt);
      end
    end
    @(posedge ACLK);
    #1;
    chk("m_valid", 32'(m_valid), (mdl_full && mdl_tgt < N) ? 32'(1) << mdl_tgt : 32'h0);
    chk("err_valid", 32'(err_valid), 32'(mdl_full && mdl_tgt == N));
    if (mdl_full || rst) chk("m_addr", m_addr, mdl_addr);
    chk("resp_sel", 32'(resp_sel), 32'(mdl_sel));
    chk("outst_cnt", 32'(outst_cnt), 32'(outst_q.size()));
  endtask

  typedef struct {
    bit          rst;
    bit          v;
    logic [31:0] a;
    logic [3:0]  mr;
    bit          er;
    bit          d;
    bit          rdy;
    logic [3:0]  mv;
    bit          ev;
    bit          chk_addr;
    logic [31:0] ma;
    logic [2:0]  sel;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bit r;
    int mode;
    logic [31:0] a;

    ARESET = 1'b1; s_valid = 1'b0; s_addr = '0; m_ready = '0; err_ready = 1'b0; resp_done = 1'b0;

    //          rst v  addr            mr       er d  rdy mv       ev ca ma              sel cnt
    tbl[0]  = '{1, 0, 32'h0,          4'b0000, 0, 0, 0, 4'b0000, 0, 1, 32'h0,          0, 0};
    tbl[1]  = '{0, 1, 32'h204,        4'b0000, 0, 0, 1, 4'b0010, 0, 1, 32'h004,        1, 1};
    tbl[2]  = '{0, 0, 32'h204,        4'b0010, 0, 0, 1, 4'b0000, 0, 0, 32'h0,          1, 1};
    tbl[3]  = '{0, 0, 32'h204,        4'b0000, 0, 1, 1, 4'b0000, 0, 0, 32'h0,          1, 0};
    tbl[4]  = '{0, 1, 32'h800,        4'b0000, 0, 0, 1, 4'b0000, 1, 1, 32'h800,        4, 1};
    tbl[5]  = '{0, 0, 32'h800,        4'b0000, 1, 1, 1, 4'b0000, 0, 0, 32'h0,          4, 0};
    tbl[6]  = '{0, 1, 32'h10,         4'b0000, 0, 0, 1, 4'b0001, 0, 1, 32'h10,         0, 1};
    tbl[7]  = '{0, 1, 32'h14,         4'b0001, 0, 0, 1, 4'b0001, 0, 1, 32'h14,         0, 2};
    tbl[8]  = '{0, 1, 32'h18,         4'b0001, 0, 0, 1, 4'b0001, 0, 1, 32'h18,         0, 3};
    tbl[9]  = '{1, 1, 32'h1C,         4'b0000, 0, 0, 0, 4'b0000, 0, 1, 32'h0,          0, 0};
    tbl[10] = '{0, 0, 32'h0,          4'b0000, 0, 1, 1, 4'b0000, 0, 0, 32'h0,          0, 0};
    tbl[11] = '{0, 1, 32'hFFFF_FFFF,  4'b0000, 0, 0, 1, 4'b0000, 1, 1, 32'hFFFF_FFFF,  4, 1};
    tbl[12] = '{0, 0, 32'hFFFF_FFFF,  4'b0000, 1, 1, 1, 4'b0000, 0, 0, 32'h0,          4, 0};

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].mr, tbl[i].er, tbl[i].d, r);
      chk($sformatf("vec%0d_ready", i), 32'(r), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_mvalid", i), 32'(m_valid), 32'(tbl[i].mv));
      chk($sformatf("vec%0d_err", i), 32'(err_valid), 32'(tbl[i].ev));
      if (tbl[i].chk_addr) chk($sformatf("vec%0d_maddr", i), m_addr, tbl[i].ma);
      chk($sformatf("vec%0d_sel", i), 32'(resp_sel), 32'(tbl[i].sel));
      chk($sformatf("vec%0d_cnt", i), 32'(outst_cnt), 32'(tbl[i].cnt));
    end

    // Outstanding limit, with a same-cycle completion freeing the fifth slot.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'h10, 4'hF, 0, 0, r);
      chk("lim_accept", 32'(r), 32'd1);
    end
    step(0, 1, 32'h10, 4'hF, 0, 0, r);
    chk("lim_stall", 32'(r), 32'd0);
    step(0, 1, 32'h10, 4'hF, 0, 1, r);
    chk("lim_credit_accept", 32'(r), 32'd1);
    chk("lim_cnt_hold", 32'(outst_cnt), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 4'hF, 0, 1, r);
    chk("lim_drained", 32'(outst_cnt), 32'd0);

    // Stream switch waits for the count to reach zero.
    step(0, 1, 32'h0, 4'hF, 0, 0, r);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h600, 4'hF, 0, 0, r);
      chk("sw_stall", 32'(r), 32'd0);
    end
    step(0, 1, 32'h600, 4'hF, 0, 1, r);
    chk("sw_stall_on_done", 32'(r), 32'd0);
    chk("sw_cnt_zero", 32'(outst_cnt), 32'd0);
    step(0, 1, 32'h600, 4'h0, 0, 0, r);
    chk("sw_accept", 32'(r), 32'd1);
    chk("sw_mvalid", 32'(m_valid), 32'b1000);
    chk("sw_maddr", m_addr, 32'h0);
    chk("sw_sel", 32'(resp_sel), 32'd3);
    step(0, 0, 32'h0, 4'hF, 0, 1, r);

    // Backpressure from slave 2 holds the stage; other slaves' ready is irrelevant.
    step(0, 1, 32'h400, 4'h0, 0, 0, r);
    chk("bp_accept", 32'(r), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 32'h404, 4'b1011, 0, 0, r);
      chk("bp_stall", 32'(r), 32'd0);
      chk("bp_mvalid_hold", 32'(m_valid), 32'b0100);
      chk("bp_maddr_hold", m_addr, 32'h0);
    end
    step(0, 1, 32'h404, 4'b0100, 0, 0, r);
    chk("bp_fire_accept", 32'(r), 32'd1);
    chk("bp_new_maddr", m_addr, 32'h4);
    chk("bp_cnt", 32'(outst_cnt), 32'd2);
    step(0, 0, 32'h0, 4'hF, 0, 1, r);
    step(0, 0, 32'h0, 4'hF, 0, 1, r);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      mode = int'($urandom_range(0, 5));
      case (mode)
        0, 1: a = $urandom_range(0, 32'h7FF);
        2:    a = mdl_full ? mdl_addr + mdl_sel * 512 : $urandom_range(0, 32'h7FF);
        3:    a = $urandom_range(32'h800, 32'hFFF);
        4:    a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), a,
           4'($urandom), bit'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
